// File: rtl/disparity_drain_pkg.sv
// Shared definitions for the disparity drain block.
//   - FIFO entry layout: [19:14] disparity, [13:0] aggregated cost
//   - FSM state encoding
//   - disparity -> 8-bit grayscale helper
package disparity_drain_pkg;

  localparam int ENTRY_W  = 20;
  localparam int DISP_MSB = 19;
  localparam int DISP_LSB = 14;
  localparam int COST_MSB = 13;
  localparam int DISP_W   = DISP_MSB - DISP_LSB + 1;
  localparam int COST_W   = COST_MSB + 1;
  localparam int PIX_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Stretch 6-bit disparity to the full 8-bit range by replicating its MSBs,
  // so 0 maps to 00 and 63 maps to FF.
  function automatic logic [PIX_W-1:0] disp_gray(input logic [DISP_W-1:0] d);
    return {d, d[DISP_W-1 -: 2]};
  endfunction

endpackage

// File: rtl/disparity_drain_disp_to_gray.sv
// disp_to_gray: combinational mapping of one FIFO entry to a grayscale pixel.
// Optional macro CONFIDENCE_CHECK_EN: entries whose cost exceeds COST_THRESH
// are replaced by the invalid marker 8'h00 (cost equal to the threshold passes).
// Ports:
//   entry_i  FIFO entry {disparity, cost}
//   pix_o    grayscale pixel
module disp_to_gray
  import disparity_drain_pkg::*;
#(
  parameter logic [COST_W-1:0] COST_THRESH = 14'h0FFF
) (
  input  logic [ENTRY_W-1:0] entry_i,
  output logic [PIX_W-1:0]   pix_o
);

  logic [DISP_W-1:0] disp;
  logic [COST_W-1:0] cost;

  assign disp = entry_i[DISP_MSB:DISP_LSB];
  assign cost = entry_i[COST_MSB:0];

`ifdef CONFIDENCE_CHECK_EN
  assign pix_o = (cost > COST_THRESH) ? '0 : disp_gray(disp);
`else
  // Cost and threshold have no effect in this build.
  logic unused_cost;
  assign unused_cost = ^{cost, COST_THRESH};
  assign pix_o       = disp_gray(disp);
`endif

endmodule

// File: rtl/disparity_drain.sv
// disparity_drain: after start, pops exactly ROW_WIDTH min-cost entries from a
// first-word-fall-through FIFO and streams them out as grayscale pixels over a
// valid/ready interface, flagging the last pixel of the row.
// Optional macro CONFIDENCE_CHECK_EN: high-cost entries become 8'h00.
// Ports:
//   clock, reset_n          clock / async active-low reset
//   start                   row aggregated, begin draining (ignored unless idle)
//   fifo_empty, fifo_data   FWFT FIFO head; fifo_read pops it
//   pix_valid/ready/data/last  pixel stream
//   busy                    not idle
//   done                    pulse the cycle after the last pixel handshake
//   err_excess              sticky: FIFO still held data when the row completed
module disparity_drain
  import disparity_drain_pkg::*;
#(
  parameter int                ROW_WIDTH   = 320,
  parameter logic [COST_W-1:0] COST_THRESH = 14'h0FFF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               fifo_empty,
  input  logic [ENTRY_W-1:0] fifo_data,
  output logic               fifo_read,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [PIX_W-1:0]   pix_data,
  output logic               pix_last,
  output logic               busy,
  output logic               done,
  output logic               err_excess
);

  localparam int             CW       = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_COL = CW'(ROW_WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    col_q;
  logic             pix_valid_q, pix_last_q, done_q, err_q;
  logic [PIX_W-1:0] pix_data_q, pix_d;
  logic             hs;

  disp_to_gray #(.COST_THRESH(COST_THRESH)) u_gray (
    .entry_i (fifo_data),
    .pix_o   (pix_d)
  );

  assign hs = pix_valid_q & pix_ready;

  // Pop only while the output slot is free or being emptied this cycle. The row
  // length bound is implicit: DRAIN is left on the pop of the last column.
  assign fifo_read = (state_q == ST_DRAIN) & ~fifo_empty & (~pix_valid_q | pix_ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (done_q && !fifo_empty) err_q <= 1'b1;

      if (fifo_read) begin
        pix_valid_q <= 1'b1;
        pix_data_q  <= pix_d;
        pix_last_q  <= (col_q == LAST_COL);
      end else if (hs) begin
        pix_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            col_q   <= '0;
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Counter holds at LAST_COL rather than wrapping.
          if (fifo_read) begin
            if (col_q == LAST_COL) state_q <= ST_FLUSH;
            else                   col_q   <= col_q + CW'(1);
          end
        end
        ST_FLUSH: begin
          if (hs && pix_last_q) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign pix_last   = pix_last_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign err_excess = err_q;

endmodule

// File: tb/tb_disparity_drain.sv
module tb_disparity_drain;

  localparam int RW = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        fifo_empty, fifo_read;
  logic [19:0] fifo_data;
  logic        pix_valid, pix_ready, pix_last, busy, done, err_excess;
  logic [7:0]  pix_data;

  logic rdy_base = 1'b1;
  logic tog_mode = 1'b0;
  logic tog_q = 1'b0;
  assign pix_ready = tog_mode ? tog_q : rdy_base;

  always #5 clock = ~clock;

  // FWFT FIFO model
  logic [19:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = mem[rd_ptr[3:0]];
  always @(posedge clock) if (fifo_read) rd_ptr <= rd_ptr + 1;
  always @(posedge clock) tog_q <= ~tog_q;

  disparity_drain #(.ROW_WIDTH(RW), .COST_THRESH(14'd100)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read(fifo_read),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_last(pix_last), .busy(busy), .done(done), .err_excess(err_excess)
  );

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  logic [8:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    logic exp_done;
    logic hold_pend;
    logic [8:0] held;
    logic [8:0] e;
    exp_done  = 1'b0;
    hold_pend = 1'b0;
    held      = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        exp_done  = 1'b0;
        hold_pend = 1'b0;
      end else begin
        if (done || exp_done) chk("done_pulse", 32'(done), 32'(exp_done));
        exp_done = 1'b0;
        if (hold_pend) begin
          chk("hold_stable", 32'({pix_valid, pix_last, pix_data}), 32'({1'b1, held}));
          hold_pend = 1'b0;
        end
        if (fifo_read) chk("read_when_empty", 32'(fifo_empty), 32'd0);
        if (pix_valid && !pix_ready) begin
          chk("read_while_held", 32'(fifo_read), 32'd0);
          held      = {pix_last, pix_data};
          hold_pend = 1'b1;
        end
        if (pix_valid && pix_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pixel actual=%h expected=none", {pix_last, pix_data});
          end else begin
            e = exp_q.pop_front();
            chk("pixel", 32'({pix_last, pix_data}), 32'(e));
            if (e[8]) exp_done = 1'b1;
          end
        end
      end
    end
  end

  task automatic push(input logic [5:0] d, input logic [13:0] c,
                      input logic want, input logic [8:0] exp);
    mem[wr_ptr[3:0]] = {d, c};
    wr_ptr = wr_ptr + 1;
    if (want) exp_q.push_back(exp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (1) begin
      @(posedge clock); #1;
      cyc++;
      if (done || cyc >= budget) break;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic push_std_row();
    push(6'd0,  14'd0, 1'b1, {1'b0, 8'h00});
    push(6'd1,  14'd0, 1'b1, {1'b0, 8'h04});
    push(6'd32, 14'd0, 1'b1, {1'b0, 8'h82});
    push(6'd63, 14'd0, 1'b1, {1'b1, 8'hFF});
  endtask

  task automatic end_checks(input logic exp_err, input int exp_left);
    @(posedge clock); #1;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("err_excess", 32'(err_excess), 32'(exp_err));
    chk("fifo_left", 32'(wr_ptr - rd_ptr), 32'(exp_left));
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    int base;
    logic [7:0] c1;
    logic [7:0] c2;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_outputs", 32'({fifo_read, pix_valid, pix_data, pix_last, busy, done, err_excess}), 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Full throughput row
    push_std_row();
    pulse_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done(30, cyc);
    chk("row_latency", 32'(cyc), 32'd5);
    end_checks(1'b0, 0);

    // Ready toggling
    tog_mode = 1'b1;
    push_std_row();
    pulse_start();
    wait_done(40, cyc);
    tog_mode = 1'b0;
    end_checks(1'b0, 0);

    // Mid-row underflow stall
    push(6'd0, 14'd0, 1'b1, {1'b0, 8'h00});
    push(6'd1, 14'd0, 1'b1, {1'b0, 8'h04});
    pulse_start();
    repeat (10) @(posedge clock);
    #1;
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_valid", 32'(pix_valid), 32'd0);
    push(6'd32, 14'd0, 1'b1, {1'b0, 8'h82});
    push(6'd63, 14'd0, 1'b1, {1'b1, 8'hFF});
    wait_done(30, cyc);
    end_checks(1'b0, 0);

    // Cost threshold boundary
`ifdef CONFIDENCE_CHECK_EN
    c1 = 8'h00;
    c2 = 8'h00;
`else
    c1 = 8'h28;
    c2 = 8'h04;
`endif
    push(6'd10, 14'd100,    1'b1, {1'b0, 8'h28});
    push(6'd10, 14'd101,    1'b1, {1'b0, c1});
    push(6'd63, 14'd0,      1'b1, {1'b0, 8'hFF});
    push(6'd1,  14'h3FFF,   1'b1, {1'b1, c2});
    pulse_start();
    wait_done(30, cyc);
    end_checks(1'b0, 0);

    // Excess entry: fifth entry stays in the FIFO
    push_std_row();
    push(6'd5, 14'd0, 1'b0, 9'd0);
    pulse_start();
    wait_done(30, cyc);
    end_checks(1'b1, 1);
    wr_ptr = rd_ptr;

    // Reset mid-row
    base = hs_cnt;
    push(6'd5, 14'd0, 1'b1, {1'b0, 8'h14});
    push(6'd6, 14'd0, 1'b1, {1'b0, 8'h18});
    push(6'd7, 14'd0, 1'b0, 9'd0);
    push(6'd8, 14'd0, 1'b0, 9'd0);
    pulse_start();
    cyc = 0;
    while (hs_cnt < base + 2 && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk("two_pixels_seen", 32'(hs_cnt - base), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("midrow_rst_outputs", 32'({fifo_read, pix_valid, pix_data, pix_last, busy, done, err_excess}), 32'd0);
    chk("midrow_fifo_left", 32'(wr_ptr - rd_ptr), 32'd1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("rst_hold_left", 32'(wr_ptr - rd_ptr), 32'd1);
    wr_ptr = rd_ptr;
    reset_n = 1'b1;
    @(posedge clock); #1;
    push_std_row();
    pulse_start();
    wait_done(30, cyc);
    chk("fresh_row_latency", 32'(cyc), 32'd5);
    end_checks(1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disparity_drain.md
DISPARITY_DRAIN -- requirements
Module: disparity_drain

Interface
REQ-001 Parameter: ROW_WIDTH, 320, pixels per image row drained per start.
REQ-002 Parameter: COST_THRESH, 14'h0FFF, max accepted aggregated cost (used only with CONFIDENCE_CHECK_EN).
REQ-003 Port: clock  in  1  single clock; all logic rising-edge.
REQ-004 Port: reset_n  in  1  asynchronous active-low reset.
REQ-005 Port: start  in  1  one-cycle pulse: all disparities for the row are aggregated; begin draining.
REQ-006 Port: fifo_empty  in  1  empty flag of the upstream min-cost FIFO.
REQ-007 Port: fifo_data  in  20  first-word-fall-through head entry: [19:14] disparity, [13:0] cost.
REQ-008 Port: fifo_read  out  1  pop request to the FIFO; head entry is consumed that cycle.
REQ-009 Port: pix_valid  out  1  pix_data is valid.
REQ-010 Port: pix_ready  in  1  downstream accepts pix_data when pix_valid and pix_ready are both high.
REQ-011 Port: pix_data  out  8  grayscale disparity pixel.
REQ-012 Port: pix_last  out  1  marks the final pixel of the row; qualified by pix_valid.
REQ-013 Port: busy  out  1  high while not in IDLE.
REQ-014 Port: done  out  1  one-cycle pulse after the last pixel handshake.
REQ-015 Port: err_excess  out  1  sticky: FIFO non-empty when the row completed.

Function
REQ-016 FSM states SHALL be IDLE, DRAIN, FLUSH.
REQ-017 IDLE->DRAIN on start; column counter cleared to 0. start SHALL be ignored outside IDLE.
REQ-018 In DRAIN, fifo_read = !fifo_empty && (!pix_valid || pix_ready) && (issued count < ROW_WIDTH); fifo_read SHALL never assert when fifo_empty or outside DRAIN.
REQ-019 On a fifo_read cycle the output register SHALL load next cycle: pix_valid=1, pix_data = {disp[5:0], disp[5:4]}; latency FIFO pop to pix_valid is 1 cycle.
REQ-020 pix_data/pix_last SHALL stay stable while pix_valid && !pix_ready.
REQ-021 pix_valid SHALL clear after handshake unless a new pop occurs the same cycle (full throughput: one pixel per cycle with pix_ready held high).
REQ-022 pix_last SHALL be 1 on the pixel whose column index equals ROW_WIDTH-1.
REQ-023 After ROW_WIDTH pops the FSM SHALL enter FLUSH; FLUSH->IDLE on handshake of the pix_last pixel, with done pulsed that cycle.
REQ-024 If fifo_empty is 0 in the cycle done pulses, err_excess SHALL set and hold until reset.
REQ-025 FIFO empty mid-row SHALL stall DRAIN indefinitely (no timeout, no pixel emitted).
REQ-026 Column counter width SHALL be $clog2(ROW_WIDTH); it SHALL never wrap past ROW_WIDTH-1.

Reset
REQ-027 reset_n low SHALL force IDLE, counter 0, fifo_read 0, pix_valid 0, pix_data 0, pix_last 0, busy 0, done 0, err_excess 0, regardless of operation in progress.
REQ-028 Reset mid-row SHALL discard the row; leftover FIFO contents are not popped.

Configuration
REQ-029 Macro CONFIDENCE_CHECK_EN defined: a popped entry with cost > COST_THRESH SHALL produce pix_data 8'h00 (invalid marker); cost == COST_THRESH passes.
REQ-030 Macro undefined: cost bits SHALL be ignored and COST_THRESH unused; pixel mapping per REQ-019 only.

Structure
REQ-031 Shared package SHALL hold field constants DISP_MSB=19, DISP_LSB=14, COST_MSB=13, the FIFO entry width 20, and the FSM state encoding.
REQ-032 One sub-module, disp_to_gray, SHALL implement the combinational disparity-to-pixel mapping including the optional confidence check.

Verification
REQ-033 ROW_WIDTH=4, FIFO preloaded with disparities 0,1,32,63 (cost 0), start, pix_ready=1 -> pix_data 00,04,82,FF on 4 consecutive cycles, pix_last on 4th, done 1 cycle later, err_excess 0.
REQ-034 Same row, pix_ready toggling 1/0 each cycle -> identical pixel sequence, no duplicates/drops, fifo_read never high while output held.
REQ-035 FIFO empty after 2 entries, refilled 10 cycles later -> stall with busy=1, pix_valid low after 2nd handshake, resumes correctly.
REQ-036 FIFO with 5 entries, ROW_WIDTH=4 -> 4 pixels, done, err_excess=1, 5th entry not popped.
REQ-037 CONFIDENCE_CHECK_EN, COST_THRESH=100, costs 100 and 101 with disparity 10 -> pix_data 28 then 00.
REQ-038 reset_n pulsed low after 2nd pixel -> all outputs 0 immediately, state IDLE, next start drains a fresh row from column 0.
